// File: rtl/cc_unit.sv
// Condition-code unit: registers zero/sign/overflow flags from ALU results
// and evaluates jXX/cmovXX conditions from the registered flags.
module cc_unit (
  input  logic               clk,
  input  logic               rst,
  input  logic               alu_valid,
  input  logic               set_cc,
  input  logic               stall,
  input  logic [3:0]         alu_fun,
  input  logic signed [63:0] A,
  input  logic signed [63:0] B,
  input  logic signed [63:0] result,
  input  logic [3:0]         ifun,
  output logic               zf,
  output logic               sf,
  output logic               of,
  output logic               cnd,
  output logic [7:0]         upd_cnt
);

  localparam logic [3:0] FUN_ADD = 4'd0;
  localparam logic [3:0] FUN_SUB = 4'd1;
  localparam logic [3:0] FUN_MAX = 4'd3;

  // Overflow is judged from operand and result signs only; the ALU output is trusted as given.
  function automatic logic calc_of(input logic [3:0] fun, input logic a_s, input logic b_s,
                                   input logic r_s);
    logic o;
    case (fun)
      FUN_ADD: o = (a_s == b_s) && (r_s != b_s);
      FUN_SUB: o = (a_s != b_s) && (r_s != b_s);
      default: o = 1'b0;
    endcase
    return o;
  endfunction

  logic accept_s;
  logic new_zf_s;
  logic new_sf_s;
  logic new_of_s;
  logic lt_s;

  // Update qualification and next-flag values.
  always_comb begin
    accept_s = set_cc && alu_valid && !stall && (alu_fun <= FUN_MAX);
    new_zf_s = (result == 64'sd0);
    new_sf_s = result[63];
    new_of_s = calc_of(alu_fun, A[63], B[63], result[63]);
  end

  // Flag and update-counter registers; reset beats stall and any update.
  always_ff @(posedge clk) begin
    if (rst) begin
      zf      <= 1'b1;
      sf      <= 1'b0;
      of      <= 1'b0;
      upd_cnt <= 8'd0;
    end else if (accept_s) begin
      zf      <= new_zf_s;
      sf      <= new_sf_s;
      of      <= new_of_s;
      upd_cnt <= upd_cnt + 8'd1;
    end else begin
      zf      <= zf;
      sf      <= sf;
      of      <= of;
      upd_cnt <= upd_cnt;
    end
  end

  // Condition evaluation from the flags already held in the registers.
  always_comb begin
    lt_s = sf ^ of;
    case (ifun)
      4'd0:    cnd = 1'b1;
      4'd1:    cnd = lt_s | zf;
      4'd2:    cnd = lt_s;
      4'd3:    cnd = zf;
      4'd4:    cnd = !zf;
      4'd5:    cnd = !lt_s;
      4'd6:    cnd = !lt_s && !zf;
      default: cnd = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_cc_unit.sv
// Self-checking bench for cc_unit: vector table with expected flags pushed to
// a scoreboard queue on drive and compared after the clock edge.
module tb_cc_unit;

  logic               clk = 1'b0;
  logic               rst, alu_valid, set_cc, stall;
  logic [3:0]         alu_fun, ifun;
  logic signed [63:0] A, B, result;
  logic               zf, sf, of, cnd;
  logic [7:0]         upd_cnt;

  int total = 0;
  int bad   = 0;

  localparam logic signed [63:0] MAXV = 64'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [63:0] MINV = 64'sh8000_0000_0000_0000;

  typedef struct {
    logic               r, sc, v, st;
    logic [3:0]         fun;
    logic signed [63:0] a, b, res;
    logic [3:0]         ifn;
    logic               ezf, esf, eof, ecnd;
    logic [7:0]         ecnt;
  } vec_t;

  typedef struct {
    string      name;
    logic       zf, sf, of, cnd;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[12];

  cc_unit dut (
    .clk(clk), .rst(rst), .alu_valid(alu_valid), .set_cc(set_cc), .stall(stall),
    .alu_fun(alu_fun), .A(A), .B(B), .result(result), .ifun(ifun),
    .zf(zf), .sf(sf), .of(of), .cnd(cnd), .upd_cnt(upd_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, sc, v, st, input logic [3:0] fun,
                              input logic signed [63:0] a, b, res, input logic [3:0] ifn,
                              input logic ezf, esf, eof, ecnd, input logic [7:0] ecnt);
    vec_t t;
    t.r = r; t.sc = sc; t.v = v; t.st = st; t.fun = fun;
    t.a = a; t.b = b; t.res = res; t.ifn = ifn;
    t.ezf = ezf; t.esf = esf; t.eof = eof; t.ecnd = ecnd; t.ecnt = ecnt;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one vector at the falling edge, queue its expectation, compare after the rising edge.
  task automatic apply(input string name, input vec_t t);
    exp_t e, p;
    @(negedge clk);
    rst = t.r; set_cc = t.sc; alu_valid = t.v; stall = t.st; alu_fun = t.fun;
    A = t.a; B = t.b; result = t.res; ifun = t.ifn;
    e.name = name; e.zf = t.ezf; e.sf = t.esf; e.of = t.eof; e.cnd = t.ecnd; e.cnt = t.ecnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      p = sb.pop_front();
      chk({p.name, ".zf"},  {63'd0, zf},  {63'd0, p.zf});
      chk({p.name, ".sf"},  {63'd0, sf},  {63'd0, p.sf});
      chk({p.name, ".of"},  {63'd0, of},  {63'd0, p.of});
      chk({p.name, ".cnd"}, {63'd0, cnd}, {63'd0, p.cnd});
      chk({p.name, ".cnt"}, {56'd0, upd_cnt}, {56'd0, p.cnt});
    end
  endtask

  initial begin
    logic [7:0] cnd_exp;
    vec_t t;
    rst = 1'b1; set_cc = 1'b0; alu_valid = 1'b0; stall = 1'b0; alu_fun = 4'd0;
    A = 64'sd0; B = 64'sd0; result = 64'sd0; ifun = 4'd0;

    // Reset with stall and set_cc both high still loads reset values.
    apply("rst_stall", mk(1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 64'sd1, 64'sd1, 64'sd2, 4'd3,
                          1'b1, 1'b0, 1'b0, 1'b1, 8'd0));

    // After reset, sweep every defined condition code.
    cnd_exp = 8'b0010_1011;
    @(negedge clk);
    rst = 1'b0; set_cc = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ifun = 4'(i);
      #1;
      chk($sformatf("rst_cnd%0d", i), {63'd0, cnd}, {63'd0, cnd_exp[i]});
    end
    chk("rst_cnt", {56'd0, upd_cnt}, 64'd0);

    tbl[0]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, MAXV, 64'sd1, MINV, 4'd2, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1);
    tbl[1]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 64'sd1, MINV, MAXV, 4'd1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2);
    tbl[2]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 64'sd4, 64'sd12, 64'sd4, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3);
    tbl[3]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 64'sd714278, 64'sd714278, 64'sd0, 4'd4,
                 1'b0, 1'b0, 1'b0, 1'b1, 8'd3);
    tbl[4]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 64'sd714278, 64'sd714278, 64'sd0, 4'd3,
                 1'b1, 1'b0, 1'b0, 1'b1, 8'd4);
    tbl[5]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, -64'sd3, -64'sd2, -64'sd5, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4);
    tbl[6]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 4'd5, -64'sd3, -64'sd2, -64'sd5, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd4);
    tbl[7]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, -64'sd3, -64'sd2, -64'sd5, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4);
    tbl[8]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, -64'sd3, -64'sd2, -64'sd5, 4'd2, 1'b0, 1'b1, 1'b0, 1'b1, 8'd5);
    tbl[9]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 64'sd5, 64'sd3, -64'sd2, 4'd6, 1'b0, 1'b1, 1'b0, 1'b0, 8'd6);
    tbl[10] = mk(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, MINV, MINV, 64'sd0, 4'd1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd7);
    tbl[11] = mk(1'b0, 1'b1, 1'b1, 1'b0, 4'd15, 64'sd1, 64'sd1, 64'sd0, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 8'd7);
    for (int i = 0; i < 12; i++) apply($sformatf("vec%0d", i), tbl[i]);

    // cnd must reflect an update only after the edge that loads it.
    apply("pre_clear", mk(1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 64'sd1, 64'sd1, 64'sd1, 4'd3,
                          1'b0, 1'b0, 1'b0, 1'b0, 8'd8));
    @(negedge clk);
    set_cc = 1'b1; alu_valid = 1'b1; stall = 1'b0; alu_fun = 4'd3;
    A = 64'sd714278; B = 64'sd714278; result = 64'sd0; ifun = 4'd3;
    #1;
    chk("cnd_before_edge", {63'd0, cnd}, 64'd0);
    @(posedge clk);
    #1;
    chk("cnd_after_edge", {63'd0, cnd}, 64'd1);

    // Counter wrap: reset then 256 accepted updates.
    apply("wrap_rst", mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 64'sd0, 64'sd0, 64'sd0, 4'd0,
                         1'b1, 1'b0, 1'b0, 1'b1, 8'd0));
    for (int i = 0; i < 256; i++) begin
      t = mk(1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 64'(i), 64'sd0, 64'(i), 4'd4,
             (i == 0), 1'b0, 1'b0, (i != 0), 8'(i + 1));
      apply($sformatf("wrap%0d", i), t);
    end
    chk("wrap_zero", {56'd0, upd_cnt}, 64'd0);
    apply("mid1", mk(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, MAXV, 64'sd1, MINV, 4'd2, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1));
    apply("mid2", mk(1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 64'sd1, MINV, MAXV, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2));
    apply("rst_with_upd", mk(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, MAXV, 64'sd1, MINV, 4'd4,
                             1'b1, 1'b0, 1'b0, 1'b0, 8'd0));

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
